serial_magnitude_comparator: RTL and testbench
==============================================

# serial_magnitude_comparator

Parametrised, digit-serial magnitude comparator with valid/ready handshakes on both sides. It is the next generation of the team's single-bit serialized comparator. Operands are latched in one transfer and compared MSB-first, DIGIT bits per cycle, in unsigned or two's-complement mode. It terminates early at the first differing digit and returns a one-hot less/equal/greater result plus the number of digits consumed. It sits between an operand source (sorter, arbiter, threshold checker) and a consumer that can apply backpressure.

## Interface
- WIDTH, 16, operand width in bits; ≥ 2.
- DIGIT, 1, bits compared per cycle; WIDTH % DIGIT == 0 (elaboration error otherwise). NDIG = WIDTH/DIGIT.
- CW, $clog2(NDIG)+1, width of digits_used (derived, not overridden).
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  high only in IDLE.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- signed_in  input  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- less_than  output  1  A < B.
- equal_to  output  1  A == B.
- greater_than  output  1  A > B.
- digits_used  output  CW  digits examined to reach the result, 1..NDIG.

## Operation
- States: IDLE, COMPARE, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid && in_ready at an edge: latch a_in, b_in and signed_in into shift registers; clear the digit counter; clear less_than/equal_to/greater_than to 000; go to COMPARE.
- Signed mode: invert bit WIDTH-1 of both latched operands at capture. This maps to offset binary, so the same unsigned digit compare is used thereafter.
- COMPARE: each cycle, compare the top DIGIT bits of A and B as unsigned values.
  - If the digits differ: register less_than/greater_than from that digit, set equal_to=0, set digits_used = counter+1, go to DONE.
  - If they are equal and this is digit NDIG-1: register 010, set digits_used=NDIG, go to DONE.
  - Otherwise: shift both operands left by DIGIT and increment the counter.
- DONE: out_valid=1. less_than, equal_to, greater_than and digits_used are stable. Exactly one of the three result bits is 1. On out_valid && out_ready, go to IDLE; the result bits stay stable but are no longer valid.
- in_valid outside IDLE is ignored. Input ports are not sampled after capture, so operand changes mid-compare have no effect.
- There is no same-cycle turnaround: in_ready rises the cycle after the output handshake.
- Reset in any state (including mid-COMPARE or DONE with out_ready low) aborts the operation. At the reset edge:
  - state goes to IDLE;
  - outputs become in_ready=1, out_valid=0, less_than=equal_to=greater_than=0, digits_used=0.
  - in_valid is ignored in the reset cycle.

## Timing
- Edge E0: input handshake. The first differing digit has index k (0 = most significant).
- Result is registered at edge E(k+1); out_valid is high in the cycle after E(k+1).
- Latency is k+1 cycles; maximum NDIG cycles, reached for equal operands or a difference only in the last digit.
- Minimum initiation interval: latency + 2 cycles (DONE with out_ready=1, then IDLE).
- in_ready and out_valid are decoded from registered state only; there is no combinational path from inputs to outputs.
- out_ready low in DONE holds all outputs indefinitely.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1. Required: in_ready=1, out_valid=0, result bits 000, digits_used=0, no capture.
- WIDTH=8, DIGIT=2, unsigned, a=0xA5, b=0xA5, out_ready=1. Required: out_valid 4 cycles after accept, result 010, digits_used=4; in_ready returns the cycle after the handshake.
- WIDTH=8, DIGIT=2:
  - unsigned, a=0x80, b=0x7F → 001, digits_used=1, latency 1.
  - same operands signed → 100, digits_used=1.
  - signed, a=0xFF, b=0xFE → 001, digits_used=4.
- WIDTH=8, DIGIT=2, unsigned, a=0x34, b=0x37, out_ready=0 for 5 cycles, then 1. Required: 100, digits_used=4, held stable for all 5 stall cycles. in_valid with new operands during the stall is ignored; in_ready stays 0.
- Reset mid-operation: WIDTH=16, DIGIT=1, a=0x0001, b=0x0000; assert reset at cycle 5 of COMPARE. Required: no out_valid, IDLE next cycle. A following compare of a=0x0001, b=0x0000 gives 001, digits_used=16.
- Back-to-back: WIDTH=8, DIGIT=4, three transfers with out_ready tied 1. Transfers: (0x12 vs 0x21), (0x21 vs 0x12), (0x5A vs 0x5A). Required results: 100/1, 001/1, 010/2. Each in_ready rise is exactly one cycle after the previous output handshake.

Source files
------------

// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result handshake bundle for the digit-serial magnitude comparator.
// master = operand source + result consumer, slave = comparator.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             signed_in;
  logic             out_valid;
  logic             out_ready;
  logic             less_than;
  logic             equal_to;
  logic             greater_than;
  logic [CW-1:0]    digits_used;

  modport master (
    output in_valid, a_in, b_in, signed_in, out_ready,
    input  in_ready, out_valid, less_than, equal_to, greater_than, digits_used
  );

  modport slave (
    input  in_valid, a_in, b_in, signed_in, out_ready,
    output in_ready, out_valid, less_than, equal_to, greater_than, digits_used
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first digit-serial comparator, DIGIT bits/cycle, early exit on first
// differing digit; signed operands are mapped to offset binary at capture.
module serial_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  serial_magnitude_comparator_if.slave  bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d, du_q, du_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  logic [WIDTH-1:0] sign_flip;
  logic [DIGIT-1:0] dig_a, dig_b;

  // Flipping the sign bit turns two's complement into offset binary, so the
  // unsigned digit compare below is valid for both modes.
  assign sign_flip = {bus.signed_in, {(WIDTH-1){1'b0}}};
  assign dig_a     = a_q[WIDTH-1 -: DIGIT];
  assign dig_b     = b_q[WIDTH-1 -: DIGIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      du_q    <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      du_q    <= du_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    du_d    = du_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a_in ^ sign_flip;
          b_d     = bus.b_in ^ sign_flip;
          cnt_d   = '0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (dig_a != dig_b) begin
          lt_d    = dig_a < dig_b;
          gt_d    = dig_a > dig_b;
          eq_d    = 1'b0;
          du_d    = cnt_q + CW'(1);
          state_d = DONE;
        end else if (cnt_q == CW'(NDIG - 1)) begin
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          du_d    = CW'(NDIG);
          state_d = DONE;
        end else begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.less_than    = lt_q;
  assign bus.equal_to     = eq_q;
  assign bus.greater_than = gt_q;
  assign bus.digits_used  = du_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench: three comparator configs (8/2, 16/1, 8/4) against an arithmetic
// reference (signed/unsigned compare, digit index of the highest differing bit).
module tb_serial_magnitude_comparator;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  int cfg_w[3] = '{8, 16, 8};
  int cfg_d[3] = '{2, 1, 4};

  logic        in_valid[3], out_ready[3], sgn[3];
  logic [15:0] a_drv[3], b_drv[3];
  logic        in_rdy[3], out_vld[3];
  logic [2:0]  res[3];
  logic [7:0]  du[3];

  serial_magnitude_comparator_if #(.WIDTH(8),  .DIGIT(2)) if0();
  serial_magnitude_comparator_if #(.WIDTH(16), .DIGIT(1)) if1();
  serial_magnitude_comparator_if #(.WIDTH(8),  .DIGIT(4)) if2();

  serial_magnitude_comparator #(.WIDTH(8),  .DIGIT(2)) u0 (.clk(clk), .reset(reset), .bus(if0));
  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  serial_magnitude_comparator #(.WIDTH(8),  .DIGIT(4)) u2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.in_valid = in_valid[0];  assign if0.out_ready = out_ready[0];
  assign if0.signed_in = sgn[0];
  assign if0.a_in = a_drv[0][7:0];    assign if0.b_in = b_drv[0][7:0];
  assign in_rdy[0] = if0.in_ready;    assign out_vld[0] = if0.out_valid;
  assign res[0] = {if0.less_than, if0.equal_to, if0.greater_than};
  assign du[0]  = 8'(if0.digits_used);

  assign if1.in_valid = in_valid[1];  assign if1.out_ready = out_ready[1];
  assign if1.signed_in = sgn[1];
  assign if1.a_in = a_drv[1];         assign if1.b_in = b_drv[1];
  assign in_rdy[1] = if1.in_ready;    assign out_vld[1] = if1.out_valid;
  assign res[1] = {if1.less_than, if1.equal_to, if1.greater_than};
  assign du[1]  = 8'(if1.digits_used);

  assign if2.in_valid = in_valid[2];  assign if2.out_ready = out_ready[2];
  assign if2.signed_in = sgn[2];
  assign if2.a_in = a_drv[2][7:0];    assign if2.b_in = b_drv[2][7:0];
  assign in_rdy[2] = if2.in_ready;    assign out_vld[2] = if2.out_valid;
  assign res[2] = {if2.less_than, if2.equal_to, if2.greater_than};
  assign du[2]  = 8'(if2.digits_used);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: result from integer compare; digits = index of the first digit
  // that contains the highest differing bit, or all digits when equal.
  task automatic ref_model(input int w, input int d, input logic [15:0] a, input logic [15:0] b,
                           input bit s, output logic [2:0] r, output int ndig);
    longint av, bv;
    logic [15:0] x;
    int msb;
    av = a; bv = b;
    if (s && a[w-1]) av = av - (longint'(1) << w);
    if (s && b[w-1]) bv = bv - (longint'(1) << w);
    r = (av < bv) ? 3'b100 : (av == bv) ? 3'b010 : 3'b001;
    x = a ^ b;
    msb = -1;
    for (int k = 0; k < w; k++) if (x[k]) msb = k;
    ndig = (msb < 0) ? w / d : (w - 1 - msb) / d + 1;
  endtask

  task automatic do_op(input int i, input logic [15:0] a_raw, input logic [15:0] b_raw,
                       input bit s, input int stall);
    logic [15:0] a, b, mask;
    logic [2:0]  er;
    int          ed, lat;
    mask = (cfg_w[i] == 16) ? 16'hFFFF : 16'((1 << cfg_w[i]) - 1);
    a = a_raw & mask;
    b = b_raw & mask;
    ref_model(cfg_w[i], cfg_d[i], a, b, s, er, ed);
    @(negedge clk);
    chk("in_ready_idle", in_rdy[i], 1);
    in_valid[i] = 1'b1; a_drv[i] = a; b_drv[i] = b; sgn[i] = s;
    out_ready[i] = (stall == 0);
    @(negedge clk);
    in_valid[i] = 1'b0;
    chk("in_ready_busy", in_rdy[i], 0);
    lat = 0;
    while (!out_vld[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, ed);
    chk("result", res[i], er);
    chk("digits_used", du[i], ed);
    for (int c = 0; c < stall; c++) begin
      in_valid[i] = 1'b1; a_drv[i] = 16'($urandom); b_drv[i] = 16'($urandom); sgn[i] = 1'($urandom);
      @(negedge clk);
      chk("stall_out_valid", out_vld[i], 1);
      chk("stall_in_ready", in_rdy[i], 0);
      chk("stall_result", res[i], er);
      chk("stall_digits", du[i], ed);
    end
    in_valid[i] = 1'b0;
    out_ready[i] = 1'b1;
    @(negedge clk);
    chk("post_hs_out_valid", out_vld[i], 0);
    chk("post_hs_in_ready", in_rdy[i], 1);
    chk("post_hs_result_hold", res[i], er);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int ri;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b1; out_ready[i] = 1'b0; sgn[i] = 1'b0;
      a_drv[i] = 16'h1234; b_drv[i] = 16'h4321;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", in_rdy[i], 1);
      chk("rst_out_valid", out_vld[i], 0);
      chk("rst_result", res[i], 0);
      chk("rst_digits", du[i], 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_no_capture", in_rdy[i], 1);
      chk("rst_no_valid", out_vld[i], 0);
    end

    // Directed cases
    do_op(0, 16'hA5, 16'hA5, 1'b0, 0);
    do_op(0, 16'h80, 16'h7F, 1'b0, 0);
    do_op(0, 16'h80, 16'h7F, 1'b1, 0);
    do_op(0, 16'hFF, 16'hFE, 1'b1, 0);
    do_op(0, 16'h34, 16'h37, 1'b0, 5);

    // Reset during COMPARE
    @(negedge clk);
    in_valid[1] = 1'b1; a_drv[1] = 16'h0001; b_drv[1] = 16'h0000; sgn[1] = 1'b0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", in_rdy[1], 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_in_ready", in_rdy[1], 1);
    chk("mid_rst_out_valid", out_vld[1], 0);
    chk("mid_rst_result", res[1], 0);
    chk("mid_rst_digits", du[1], 0);
    repeat (14) begin
      @(negedge clk);
      chk("mid_rst_no_valid", out_vld[1], 0);
    end
    do_op(1, 16'h0001, 16'h0000, 1'b0, 0);

    // Back-to-back
    do_op(2, 16'h12, 16'h21, 1'b0, 0);
    do_op(2, 16'h21, 16'h12, 1'b0, 0);
    do_op(2, 16'h5A, 16'h5A, 1'b0, 0);

    // Random, biased toward equal and single-bit-difference operands
    repeat (60) begin
      ri = $urandom_range(0, 2);
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (16'h1 << $urandom_range(0, cfg_w[ri] - 1));
        default: rb = 16'($urandom);
      endcase
      do_op(ri, ra, rb, 1'($urandom), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
